// File: rtl/uart_transmitter.sv
// uart_transmitter: byte FIFO feeding an 8N1 serial transmitter, MSB first.
// One bit period per rising edge of baud_rate_signal. An optional run of
// extra stop-level periods (IDLE_GAP) follows each stop bit.
module uart_transmitter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDLE_GAP   = 0
) (
  input  logic       baud_rate_signal,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic [4:0] fifo_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned GAP_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nx;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                push_c;
  logic                pop_c;
  logic [DATA_W-1:0]   head_c;

  logic [DATA_W-1:0]   shift;
  logic [DATA_W-1:0]   shift_nx;
  logic [IDX_W-1:0]    bit_idx;
  logic [IDX_W-1:0]    idx_nx;
  logic [GAP_W-1:0]    gap_cnt;
  logic [GAP_W-1:0]    gap_nx;
  logic                tx_nx;
  logic                busy_nx;
  logic                idle_eval;

  // Ready depends only on the registered occupancy, never on tx_valid.
  assign tx_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push_c   = tx_valid & tx_ready;
  assign head_c   = mem[rd_ptr];

  // FIFO storage; contents are only meaningful below fifo_count, so no reset.
  always_ff @(posedge baud_rate_signal) begin
    if (push_c) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge baud_rate_signal or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmitter state and registered line/busy outputs.
  always_ff @(posedge baud_rate_signal or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      uart_tx <= 1'b1;
      busy    <= 1'b0;
      shift   <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      uart_tx <= tx_nx;
      busy    <= busy_nx;
      shift   <= shift_nx;
      bit_idx <= idx_nx;
      gap_cnt <= gap_nx;
    end
  end

  // Next-state logic. The end of STOP (no gap) and the last GAP period reuse
  // the IDLE decision so a queued byte starts with no extra high bit.
  always_comb begin
    state_nx  = state;
    tx_nx     = 1'b1;
    busy_nx   = 1'b1;
    shift_nx  = shift;
    idx_nx    = bit_idx;
    gap_nx    = gap_cnt;
    pop_c     = 1'b0;
    idle_eval = 1'b0;

    case (state)
      S_IDLE: begin
        idle_eval = 1'b1;
      end
      S_START: begin
        tx_nx    = shift[DATA_W-1];
        idx_nx   = IDX_W'(DATA_W - 1);
        state_nx = S_DATA;
      end
      S_DATA: begin
        if (bit_idx == '0) begin
          tx_nx    = 1'b1;
          state_nx = S_STOP;
        end else begin
          tx_nx  = shift[bit_idx - IDX_W'(1)];
          idx_nx = bit_idx - IDX_W'(1);
        end
      end
      S_STOP: begin
        if (IDLE_GAP > 0) begin
          state_nx = S_GAP;
          gap_nx   = GAP_W'(IDLE_GAP - 1);
        end else begin
          idle_eval = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          idle_eval = 1'b1;
        end else begin
          gap_nx = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase

    if (idle_eval) begin
      if (fifo_count != '0) begin
        pop_c    = 1'b1;
        shift_nx = head_c;
        tx_nx    = 1'b0;
        busy_nx  = 1'b1;
        state_nx = S_START;
      end else begin
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
    end
  end

endmodule
